// File: rtl/decoder_pkg.sv
// Shared constants and the one-hot helper
// used by the binary decoder.
package decoder_pkg;

    localparam int CODE_W_DEF = 3;
    localparam int MAX_OUT_W  = 256;

    function automatic logic [MAX_OUT_W-1:0] onehot(
        input int unsigned c,
        input int unsigned w
    );
        logic [MAX_OUT_W-1:0] v;
        v = '0;
        if (c < w) begin
            v = MAX_OUT_W'(1) << c;
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational decode: one-hot generation,
// range check and output polarity.
module decoder_core
    import decoder_pkg::*;
#(
    parameter int CODE_W     = CODE_W_DEF,
    parameter int OUT_W      = 2**CODE_W,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic              en_i,
    input  logic [CODE_W-1:0] code_i,
    output logic [OUT_W-1:0]  q_o,
    output logic              valid_o,
    output logic              range_err_o
);

    logic             in_range;
    logic [OUT_W-1:0] hot;

    always_comb begin
        in_range = 32'(code_i) < 32'(OUT_W);
        hot      = '0;
        if (en_i) begin
            hot = OUT_W'(onehot(32'(code_i), 32'(OUT_W)));
        end
        // Polarity is applied last so one-cold idles at all ones.
        q_o         = ACTIVE_LOW ? ~hot : hot;
        valid_o     = en_i & in_range;
        range_err_o = en_i & ~in_range;
    end

endmodule

// File: rtl/decoder.sv
// Binary-to-one-hot decoder top with an
// optional output register stage.
module decoder
    import decoder_pkg::*;
#(
    parameter int CODE_W     = CODE_W_DEF,
    parameter int OUT_W      = 2**CODE_W,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit REGISTERED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    output logic [OUT_W-1:0]  q,
    output logic              valid,
    output logic              range_err
);

    localparam logic [OUT_W-1:0] Q_IDLE = {OUT_W{ACTIVE_LOW}};

    logic [OUT_W-1:0] q_d;
    logic             valid_d;
    logic             err_d;

    decoder_core #(
        .CODE_W    (CODE_W),
        .OUT_W     (OUT_W),
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_core (
        .en_i       (en),
        .code_i     (code),
        .q_o        (q_d),
        .valid_o    (valid_d),
        .range_err_o(err_d)
    );

    generate
        if (REGISTERED) begin : g_reg
            logic [OUT_W-1:0] q_q;
            logic             valid_q;
            logic             err_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_q     <= Q_IDLE;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                end else begin
                    q_q     <= q_d;
                    valid_q <= valid_d;
                    err_q   <= err_d;
                end
            end

            assign q         = q_q;
            assign valid     = valid_q;
            assign range_err = err_q;
        end else begin : g_comb
            assign q         = q_d;
            assign valid     = valid_d;
            assign range_err = err_d;
        end
    endgenerate

    logic [OUT_W-1:0] act;
    assign act = q ^ Q_IDLE;

    a_onehot0 : assert property (
        @(posedge clk) $onehot0(act)
    );

    a_excl : assert property (
        @(posedge clk) !(valid && range_err)
    );

    a_valid_hot : assert property (
        @(posedge clk) valid |-> $onehot(act)
    );

endmodule

// File: tb/tb_decoder.sv
// Randomized self-checking bench for decoder across
// default, narrow, one-cold and combinational builds.
module tb_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [2:0] code = 3'd0;

    logic [7:0] q_def, q_al, q_cmb;
    logic [5:0] q_w6;
    logic       v_def, v_al, v_cmb, v_w6;
    logic       e_def, e_al, e_cmb, e_w6;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit checking = 1'b0;

    bit         reg_ok = 1'b0;
    logic       reg_en = 1'b0;
    logic [2:0] reg_code = 3'd0;

    logic [7:0] tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                            8'h10, 8'h20, 8'h40, 8'h80};

    always #5 clk = ~clk;

    decoder u_def (
        .clk(clk), .rst_n(rst_n), .en(en), .code(code),
        .q(q_def), .valid(v_def), .range_err(e_def)
    );

    decoder #(.OUT_W(6)) u_w6 (
        .clk(clk), .rst_n(rst_n), .en(en), .code(code),
        .q(q_w6), .valid(v_w6), .range_err(e_w6)
    );

    decoder #(.ACTIVE_LOW(1'b1)) u_al (
        .clk(clk), .rst_n(rst_n), .en(en), .code(code),
        .q(q_al), .valid(v_al), .range_err(e_al)
    );

    decoder #(.REGISTERED(1'b0)) u_cmb (
        .clk(clk), .rst_n(rst_n), .en(en), .code(code),
        .q(q_cmb), .valid(v_cmb), .range_err(e_cmb)
    );

    // Decode rule: {q[7:0], valid, range_err} for width w.
    function automatic logic [9:0] f(
        input logic e, input logic [2:0] c,
        input int w, input bit al
    );
        logic [7:0] qv;
        logic [7:0] mask;
        logic       v;
        logic       r;
        mask = 8'((1 << w) - 1);
        qv = 8'h00;
        v = 1'b0;
        r = 1'b0;
        if (e && int'(c) < w) begin
            qv = 8'(1 << c);
            v = 1'b1;
        end else if (e) begin
            r = 1'b1;
        end
        if (al) qv = ~qv & mask;
        return {qv, v, r};
    endfunction

    function automatic logic [9:0] reg_exp(input int w, input bit al);
        if (reg_ok) return f(reg_en, reg_code, w, al);
        return f(1'b0, 3'd0, w, al);
    endfunction

    task automatic chk(input string nm, input logic [9:0] act,
                       input logic [9:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s at %0t: got q=%h v=%b e=%b, expected q=%h v=%b e=%b",
                     nm, $time, act[9:2], act[1], act[0],
                     exp[9:2], exp[1], exp[0]);
        else
            pass_cnt++;
    endtask

    // Registered outputs reflect the inputs seen at the last edge
    // taken out of reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_ok = 1'b0;
        end else begin
            reg_ok = 1'b1;
            reg_en = en;
            reg_code = code;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("def", {q_def, v_def, e_def}, reg_exp(8, 1'b0));
            chk("w6", {2'b00, q_w6, v_w6, e_w6}, reg_exp(6, 1'b0));
            chk("al", {q_al, v_al, e_al}, reg_exp(8, 1'b1));
            chk("cmb", {q_cmb, v_cmb, e_cmb}, f(en, code, 8, 1'b0));
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_def", {q_def, v_def, e_def}, {8'h00, 2'b00});
        chk("rst_al", {q_al, v_al, e_al}, {8'hFF, 2'b00});
        @(posedge clk);
        checking = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;

        en = 1'b1;
        code = 3'd0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("sweep", {q_def, v_def, e_def}, {tbl[k], 2'b10});
            if (k < 7) begin
                #1 code = 3'(k + 1);
                #1;
                chk("cmb_step", {q_cmb, v_cmb, e_cmb}, {tbl[k + 1], 2'b10});
            end
        end

        #1 en = 1'b0;
        code = 3'b101;
        @(posedge clk);
        #1 chk("en0", {q_def, v_def, e_def}, {8'h00, 2'b00});
        #1 en = 1'b1;
        @(posedge clk);
        #1 chk("en1", {q_def, v_def, e_def}, {8'h20, 2'b10});

        #1 code = 3'd6;
        @(posedge clk);
        #1 chk("w6_c6", {2'b00, q_w6, v_w6, e_w6}, {8'h00, 2'b01});
        #1 code = 3'd7;
        @(posedge clk);
        #1 chk("w6_c7", {2'b00, q_w6, v_w6, e_w6}, {8'h00, 2'b01});
        #1 code = 3'd5;
        @(posedge clk);
        #1 chk("w6_c5", {2'b00, q_w6, v_w6, e_w6}, {8'h20, 2'b10});

        #1 code = 3'b010;
        @(posedge clk);
        #1 chk("al_c2", {q_al, v_al, e_al}, {8'hFB, 2'b10});

        #1 code = 3'b111;
        @(posedge clk);
        #1 chk("stream7", {q_def, v_def, e_def}, {8'h80, 2'b10});
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_def", {q_def, v_def, e_def}, {8'h00, 2'b00});
        chk("midrst_al", {q_al, v_al, e_al}, {8'hFF, 2'b00});
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rel7", {q_def, v_def, e_def}, {8'h80, 2'b10});

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            en = ($urandom_range(0, 9) != 0);
            code = 3'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_rst", {q_def, v_def, e_def}, {8'h00, 2'b00});
                #3 rst_n = 1'b1;
            end
        end

        @(posedge clk);
        @(negedge clk);
        checking = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
